// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
//   NIBBLE_W : width of one serial slice (4 bits)
//   state_t  : sequencing states of the nibble-serial adder
//   idx_w()  : bit width of a nibble index for a given nibble count (min 1)
package arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int nib);
    return (nib < 2) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nib_add4.sv
// Combinational 4-bit ripple-carry slice.
//   a, b : nibble operands
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out of bit 3
module nib_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock, LS nibble first.
// A single nib_add4 slice is time-shared; the inter-nibble carry lives in
// carry_q. Result appears NIB cycles after the accepting edge and is held
// in DONE until out_ready.
//   clk, rst            : clock, async active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin captured on accept)
//   out_valid/ out_ready: result handshake (sum, cout[, ovf])
// Optional: define NIBBLE_SERIAL_ADDER_OVF_EN to add the ovf output
// (two's-complement signed overflow of the full-width add).
module nibble_serial_adder
  import arith_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int IDXW = idx_w(NIB);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q;
  logic [IDXW-1:0]   idx_q;
  logic [3:0]        sa, sb, ss;
  logic              sc, last, accept;

  assign sa     = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign sb     = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign last   = (idx_q == IDXW'(NIB-1));
  assign accept = in_valid && (state_q == IDLE);

  nib_add4 u_slice (
    .a    (sa),
    .b    (sb),
    .cin  (carry_q),
    .sum  (ss),
    .cout (sc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          idx_q   <= '0;
        end
        RUN: begin
          sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= ss;
          carry_q <= sc;
          idx_q   <= idx_q + 1'b1;
          if (last) cout_q <= sc;
        end
        default: ;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q;
  // Carry into the MSB is recovered from the top slice's bit 3: a^b^sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (state_q == RUN && last) ovf_q <= (sa[3] ^ sb[3] ^ ss[3]) ^ sc;
  end
  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] ai, bi, sum;
  logic         cini, cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (ai),
    .b         (bi),
    .cin       (cini),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition of the unsigned operands.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = ref_add(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Count edges from the current negedge until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
  endtask

  // Entered and left at a negedge with the block in IDLE.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input int stall, input bit hold_iv);
    logic [W:0] r;
    int n;
    r = ref_add(x, y, c);
    check("in_ready_idle", in_ready, 1);
    ai = x; bi = y; cini = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_run", in_ready, 0);
    ai = W'($urandom); bi = W'($urandom); cini = 1'($urandom);
    wait_done(n);
    check("latency", n, NIB);
    check("sum", sum, r[W-1:0]);
    check("cout", cout, r[W]);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("ovf", ovf, ref_ovf(x, y, c));
`endif
    if (hold_iv) in_valid = 1'b1;
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_sum", sum, r[W-1:0]);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W:0] r1, r2;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ai = '0; bi = '0; cini = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: carry through every nibble, partial carry, cin
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
    // Backpressure with in_valid pending through DONE
    do_op(16'h000A, 16'h0005, 1'b0, 5, 1'b1);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
`endif

    // Reset during the second RUN cycle
    ai = 16'hABCD; bi = 16'h1111; cini = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    r1 = ref_add(16'h8421, 16'h1248, 1'b1);
    r2 = ref_add(16'hF0F0, 16'h0F0F, 1'b1);
    ai = 16'h8421; bi = 16'h1248; cini = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ai = 16'hF0F0; bi = 16'h0F0F; cini = 1'b1;
    wait_done(n);
    check("b2b_latency1", n, NIB);
    check("b2b_sum1", sum, r1[W-1:0]);
    check("b2b_cout1", cout, r1[W]);
    @(posedge clk); @(negedge clk);
    check("b2b_idle_gap", in_ready, 1);
    check("b2b_idle_valid", out_valid, 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accept2", in_ready, 0);
    wait_done(n);
    check("b2b_latency2", n, NIB);
    check("b2b_sum2", sum, r2[W-1:0]);
    check("b2b_cout2", cout, r2[W]);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("b2b_release", out_valid, 0);

    // Randomized operands and stalls
    for (int t = 0; t < 40; t++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that adds two WIDTH-bit operands one 4-bit nibble per clock, least-significant nibble first.
- The carry between nibbles is held in a register, so one 4-bit ripple-carry slice serves any operand width.
- Sits in the arithmetic datapath between an operand-producing stage and a result consumer.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibbles; derived, not overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers operands.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of the top nibble.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0. The internal carry register, nibble index and operand registers are also cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: capture a, b into operand registers; carry register<=cin; index<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: sum[4*idx+:4] <= a_reg nibble + b_reg nibble + carry register, with the 4-bit sum and carry produced by the sub-module.
  - carry register <= that slice's carry out; idx <= idx+1.
  - At idx==NIB-1: write the last nibble, cout<=slice carry, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and cout are held stable until an edge with out_ready=1, then go to IDLE with out_valid=0.
- Latency: out_valid rises exactly NIB cycles after the accepting edge (4 for WIDTH=16).
- Throughput: one result per NIB+2 cycles minimum, i.e. accept, NIB RUN edges, 1 DONE edge. No IDLE/DONE bypass.
- Width and arithmetic rules: result is (a + b + cin) mod 2^WIDTH; cout is bit WIDTH of the exact sum. Operands are unsigned.
- Inputs a, b, cin are ignored outside the accepting edge; changing them during RUN has no effect.
- sum is meaningful only while out_valid=1. Nibbles are overwritten progressively during RUN.
- in_valid held high through RUN/DONE is not accepted until back in IDLE.
- Backpressure: out_ready may stay low indefinitely; the block stalls in DONE with outputs frozen.
- out_ready while not in DONE is ignored.
- Reset asserted mid-RUN or in DONE aborts immediately to reset values; the partial result is discarded.
- WIDTH=4: RUN lasts one edge.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit) reports two's-complement signed overflow.
  - ovf = carry into the MSB XOR carry out of the MSB, registered with cout and valid only with out_valid.
  - Reset value 0; held in DONE like sum.
- When undefined: port ovf and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package arith_pkg holds:
  - NIBBLE_W=4.
  - The state enumeration typedef (IDLE, RUN, DONE).
  - A helper constant function for the index width, clog2(NIB), minimum 1.
- One sub-module, nib_add4: purely combinational 4-bit ripple-carry slice.
  - Inputs: a[3:0], b[3:0], cin. Outputs: sum[3:0], cout.
  - Instantiated once; not replicated per nibble.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0, out_ready=1 → out_valid high 4 cycles after accept; sum=0x0000, cout=1.
- a=0x00FF, b=0x0001, cin=0 → sum=0x0100, cout=0, confirming inter-nibble carry propagation. Then a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
- Backpressure:
  - a=0x000A, b=0x0005, cin=0; hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, sum stays 0x000F, in_ready stays 0.
  - New in_valid is not accepted until the cycle after out_ready=1.
- Reset mid-operation: accept a=0xABCD, b=0x1111, assert rst during the 2nd RUN cycle → out_valid=0, sum=0, cout=0, in_ready=1 immediately. A following a=0x0001, b=0x0001 yields sum=0x0002.
- Back-to-back: in_valid and out_ready held high with two operand pairs → second accept occurs in the cycle after the first DONE handshake; the results are independent and correct.
- With NIBBLE_SERIAL_ADDER_OVF_EN defined:
  - a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0.
  - a=0xFFFF, b=0x0001 → ovf=0, cout=1.
